// File: rtl/bram_arbiter.sv
// Two-port (A/B) arbiter that serializes requests onto a single BRAM with registered outputs.
// Build option: define BRAM_ARB_FIXED_PRIO_EN for fixed priority (A wins ties); default is round-robin.
module bram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Req_A,
    input  logic              i_Req_B,
    input  logic              i_We_A,
    input  logic              i_We_B,
    input  logic [ADDR_W-1:0] i_Addr_A,
    input  logic [ADDR_W-1:0] i_Addr_B,
    input  logic [DATA_W-1:0] i_Wdata_A,
    input  logic [DATA_W-1:0] i_Wdata_B,
    output logic              o_Ack_A,
    output logic              o_Ack_B,
    output logic              o_Rvalid_A,
    output logic              o_Rvalid_B,
    output logic [DATA_W-1:0] o_Rdata_A,
    output logic [DATA_W-1:0] o_Rdata_B,
    output logic              o_Wr_En,
    output logic              o_Rd_En,
    output logic [ADDR_W-1:0] o_W_Addr,
    output logic [ADDR_W-1:0] o_R_Addr,
    output logic [DATA_W-1:0] o_Wr_Data,
    input  logic [DATA_W-1:0] i_Rd_Data,
    output logic              o_Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic              win_b_q;
    logic              we_q;
    logic              ack_a_q, ack_b_q;
    logic              rvalid_a_q, rvalid_b_q;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
    logic              wr_en_q, rd_en_q;
    logic [ADDR_W-1:0] w_addr_q, r_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              busy_q;
    logic              grant_b_d;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    assign grant_b_d = i_Req_B && !i_Req_A;
`else
    // last_b_q is set when B was granted last; a tie then goes to A.
    logic last_b_q;
    assign grant_b_d = i_Req_B && (!i_Req_A || !last_b_q);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            last_b_q <= 1'b1;
        end else if (state_q == IDLE && (i_Req_A || i_Req_B)) begin
            last_b_q <= grant_b_d;
        end
    end
`endif

    assign sel_we_d    = grant_b_d ? i_We_B    : i_We_A;
    assign sel_addr_d  = grant_b_d ? i_Addr_B  : i_Addr_A;
    assign sel_wdata_d = grant_b_d ? i_Wdata_B : i_Wdata_A;

    // Ack and enables are set on the edge that enters ISSUE so they are high exactly for the ISSUE cycle.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            win_b_q    <= 1'b0;
            we_q       <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            w_addr_q   <= '0;
            r_addr_q   <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_Req_A || i_Req_B) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        win_b_q <= grant_b_d;
                        we_q    <= sel_we_d;
                        ack_a_q <= !grant_b_d;
                        ack_b_q <= grant_b_d;
                        if (sel_we_d) begin
                            wr_en_q   <= 1'b1;
                            w_addr_q  <= sel_addr_d;
                            wr_data_q <= sel_wdata_d;
                        end else begin
                            rd_en_q  <= 1'b1;
                            r_addr_q <= sel_addr_d;
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (win_b_q) begin
                        rdata_b_q  <= i_Rd_Data;
                        rvalid_b_q <= 1'b1;
                    end else begin
                        rdata_a_q  <= i_Rd_Data;
                        rvalid_a_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Ack_A    = ack_a_q;
    assign o_Ack_B    = ack_b_q;
    assign o_Rvalid_A = rvalid_a_q;
    assign o_Rvalid_B = rvalid_b_q;
    assign o_Rdata_A  = rdata_a_q;
    assign o_Rdata_B  = rdata_b_q;
    assign o_Wr_En    = wr_en_q;
    assign o_Rd_En    = rd_en_q;
    assign o_W_Addr   = w_addr_q;
    assign o_R_Addr   = r_addr_q;
    assign o_Wr_Data  = wr_data_q;
    assign o_Busy     = busy_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: vector table of single transactions plus reset, tie and drop sequences.
module tb_bram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, req_b, we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          ack_a, ack_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          wr_en, rd_en;
    logic [AW-1:0] w_addr, r_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic          busy;

    logic [DW-1:0] mem [16] = '{default: 8'h00};
    logic          both_en_seen = 1'b0;
    int            pass_cnt = 0;
    int            total_cnt = 0;

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    bram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_Clk(clk), .i_Rst(rst),
        .i_Req_A(req_a), .i_Req_B(req_b), .i_We_A(we_a), .i_We_B(we_b),
        .i_Addr_A(addr_a), .i_Addr_B(addr_b), .i_Wdata_A(wdata_a), .i_Wdata_B(wdata_b),
        .o_Ack_A(ack_a), .o_Ack_B(ack_b), .o_Rvalid_A(rvalid_a), .o_Rvalid_B(rvalid_b),
        .o_Rdata_A(rdata_a), .o_Rdata_B(rdata_b), .o_Wr_En(wr_en), .o_Rd_En(rd_en),
        .o_W_Addr(w_addr), .o_R_Addr(r_addr), .o_Wr_Data(wr_data), .i_Rd_Data(rd_data),
        .o_Busy(busy)
    );

    // Registered-read BRAM model
    always @(posedge clk) begin
        if (wr_en) mem[w_addr] <= wr_data;
        if (rd_en) rd_data <= mem[r_addr];
        if (wr_en && rd_en) both_en_seen <= 1'b1;
    end

    function automatic logic [63:0] all_outs();
        return {25'd0, ack_a, ack_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
                wr_en, rd_en, w_addr, r_addr, wr_data, busy};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_req(input bit port, input bit val, input bit we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port) begin
            req_b = val; we_b = we; addr_b = addr; wdata_b = wdata;
        end else begin
            req_a = val; we_a = we; addr_a = addr; wdata_a = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction from an idle arbiter; returns at the negedge after the read data (or after ack for writes).
    task automatic do_txn(input bit port, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
        int waited;
        @(negedge clk);
        drive_req(port, 1'b1, we, addr, wdata);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(ack_a || ack_b) && waited < 10);
        check("ack_latency", waited, 1);
        check("ack_port", {ack_a, ack_b}, port ? 2'b01 : 2'b10);
        if (we) check("wr_issue", {wr_en, rd_en, w_addr, wr_data}, {1'b1, 1'b0, addr, wdata});
        else    check("rd_issue", {wr_en, rd_en, r_addr}, {1'b0, 1'b1, addr});
        drive_req(port, 1'b0, 1'b0, '0, '0);
        if (!we) begin
            @(negedge clk);
            check("rvalid_early", port ? rvalid_b : rvalid_a, 0);
            @(negedge clk);
            check("rvalid", port ? rvalid_b : rvalid_a, 1);
            check("rdata", port ? rdata_b : rdata_a, exp_rd);
        end
    endtask

    initial begin
        int grants;
        int cyc;
        int seen;
        bit exp_grant;
        rst = 1'b1;
        req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;

        vecs[0] = '{port: 1'b0, we: 1'b1, addr: 4'h3, wdata: 8'hA5, exp_rd: 8'h00};
        vecs[1] = '{port: 1'b1, we: 1'b0, addr: 4'h3, wdata: 8'h00, exp_rd: 8'hA5};
        vecs[2] = '{port: 1'b1, we: 1'b1, addr: 4'hF, wdata: 8'hFF, exp_rd: 8'h00};
        vecs[3] = '{port: 1'b0, we: 1'b1, addr: 4'h0, wdata: 8'h11, exp_rd: 8'h00};
        vecs[4] = '{port: 1'b0, we: 1'b0, addr: 4'hF, wdata: 8'h00, exp_rd: 8'hFF};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 4'h0, wdata: 8'h00, exp_rd: 8'h11};
        vecs[6] = '{port: 1'b1, we: 1'b1, addr: 4'h5, wdata: 8'h3C, exp_rd: 8'h00};
        vecs[7] = '{port: 1'b0, we: 1'b0, addr: 4'h5, wdata: 8'h00, exp_rd: 8'h3C};

        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

        // Reset in RDWAIT: outputs clear immediately and the read never completes.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 4'hF, 8'h00);
        @(negedge clk);
        check("rdwait_pre_ack", ack_a, 1);
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rdwait_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rdwait_async_reset", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rvalid_a) seen++;
        end
        check("rdwait_no_rvalid", seen, 0);
        do_txn(1'b0, 1'b0, 4'hF, 8'h00, 8'hFF);

        // Reset in ISSUE of a write: enable drops at once and the write does not land.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b1, 4'h7, 8'h77);
        @(negedge clk);
        check("issue_wr_en", wr_en, 1);
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        #1;
        check("issue_async_reset", {wr_en, ack_a, busy}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        do_txn(1'b1, 1'b0, 4'h7, 8'h00, 8'h00);

        // A request raised while busy and dropped before IDLE samples it is never acked.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b1, 4'h9, 8'h99);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b1, 1'b0, 4'h2, 8'h00);
        @(negedge clk);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack_b) seen++;
        end
        check("dropped_req_ignored", seen, 0);

        // Tie: both hold reads from a fresh reset (pointer = B).
        do_reset();
        drive_req(1'b0, 1'b1, 1'b0, 4'h1, 8'h00);
        drive_req(1'b1, 1'b1, 1'b0, 4'h2, 8'h00);
        grants = 0;
        cyc = 0;
        while (grants < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack_a || ack_b) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
                exp_grant = 1'b0;
`else
                exp_grant = grants[0];
`endif
                check("tie_grant", {ack_a, ack_b}, exp_grant ? 2'b01 : 2'b10);
                grants++;
            end
        end
        check("tie_grant_count", grants, 4);
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        cyc = 0;
        while (!ack_b && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("b_served_when_a_idle", ack_b, 1);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);

        check("never_both_enables", both_en_seen, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL provide one clock and one reset. Reset is asynchronous and active-high.
REQ-002 Parameters SHALL be ADDR_W (default 4, BRAM address width) and DATA_W (default 8, BRAM data width).
REQ-003 Ports SHALL be:
- i_Clk  in  1  clock.
- i_Rst  in  1  asynchronous active-high reset.
- i_Req_A / i_Req_B  in  1  request; held until o_Ack_x.
- i_We_A / i_We_B  in  1  1 = write, 0 = read.
- i_Addr_A / i_Addr_B  in  ADDR_W  address.
- i_Wdata_A / i_Wdata_B  in  DATA_W  write data.
- o_Ack_A / o_Ack_B  out  1  one-cycle accept pulse.
- o_Rvalid_A / o_Rvalid_B  out  1  one-cycle read-data-valid pulse.
- o_Rdata_A / o_Rdata_B  out  DATA_W  read data, valid with o_Rvalid_x.
- o_Wr_En, o_Rd_En  out  1  BRAM enables.
- o_W_Addr, o_R_Addr  out  ADDR_W  BRAM addresses.
- o_Wr_Data  out  DATA_W  BRAM write data.
- i_Rd_Data  in  DATA_W  BRAM read data, registered, valid one cycle after o_Rd_En.
- o_Busy  out  1  state != IDLE.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 The FSM SHALL have three states: IDLE, ISSUE and RDWAIT.
REQ-006 IDLE SHALL sample requests only in IDLE; with any i_Req_x high it latches the winner's We/Addr/Wdata and moves to ISSUE.
REQ-007 ISSUE SHALL last exactly one cycle, with these outputs:
- o_Ack_<winner>=1.
- Write: o_Wr_En=1, o_W_Addr/o_Wr_Data = latched values.
- Read: o_Rd_En=1, o_R_Addr = latched address.
- Next state: write -> IDLE; read -> RDWAIT.
REQ-008 RDWAIT SHALL last one cycle: it captures i_Rd_Data into o_Rdata_<winner>, pulses o_Rvalid_<winner> on the following cycle, and returns to IDLE.
REQ-009 Latency SHALL be fixed:
- Request sampled at edge N -> o_Ack at N+1.
- Write commits in BRAM at N+2.
- Read o_Rvalid at N+3.
- Throughput: 1 write per 2 cycles; 1 read per 3 cycles.
REQ-010 Enables SHALL be 0 in every state other than ISSUE; o_Wr_En and o_Rd_En are never high together.
REQ-011 o_Rdata_x SHALL hold its value until the next read for that requester.
REQ-012 Arbitration (default) SHALL be round-robin on a last-grant pointer:
- Both requests high -> grant the requester not granted last.
- Single request -> grant it; the pointer updates on every grant.
REQ-013 Requests SHALL be serialized, so read-after-write to the same address returns the new data; no bypass.
REQ-014 Address 0 and 2^ADDR_W-1 SHALL be passed unmodified; no wrap or offset logic.
REQ-015 A request dropped before ack SHALL be ignored without error; a request deasserted in the cycle after ack is not re-served.

Reset
REQ-016 Reset SHALL force:
- state=IDLE.
- Last-grant pointer = B, so A wins the first tie.
- All o_* outputs = 0, including o_Rdata_x.
REQ-017 Reset during ISSUE or RDWAIT SHALL abort the transaction: no o_Rvalid is issued, and the enables drop immediately (asynchronous).
REQ-018 After reset release, the first grant SHALL occur no earlier than the first rising edge with i_Rst low.

Configuration
REQ-019 Macro BRAM_ARB_FIXED_PRIO_EN SHALL select the arbitration mode:
- Defined: fixed priority, A always wins ties; the pointer logic is omitted.
- Undefined: round-robin per REQ-012.
- All other behaviour is identical in both modes.

Verification
REQ-020 Reset check: assert i_Rst mid-run -> all outputs 0 and o_Busy=0 without waiting for a clock edge.
REQ-021 Write then read: A writes addr 0x3 data 0xA5, then B reads 0x3 -> o_Ack_B one cycle after sampling, o_Rvalid_B=1 with o_Rdata_B=0xA5 two cycles after o_Ack_B.
REQ-022 Tie, round-robin mode: A and B both hold read requests for addrs 0x1/0x2 -> grant order A, B, A, B.
REQ-023 Tie, BRAM_ARB_FIXED_PRIO_EN defined: the same stimulus as REQ-022 gives A on every tie; B is served only when A is idle.
REQ-024 Reset during RDWAIT: A reads 0xF, reset in RDWAIT -> o_Rvalid_A never asserts; the next request is served normally.
REQ-025 Boundary addresses: write 0xFF to addr 0xF and 0x11 to addr 0x0, read both back -> 0xFF and 0x11; o_Wr_En and o_Rd_En are never high together.
